dl_rom_router: RTL and testbench
================================

DL_ROM_ROUTER -- requirements
Module: dl_rom_router

Interface
REQ-001 Parameter EXP_BYTES, default 40960, is the byte count a complete ROM image must deliver.
REQ-002 Parameter HOLD_CYC, default 16, is the number of cycles core reset is held after a download ends.
REQ-003 Parameter CHK_EXP, default 8'h00, is the expected 8-bit additive checksum of the image (used only under REQ-030).
REQ-004 Port clk_sys, input, 1: single system clock; all logic is on its rising edge.
REQ-005 Port reset_n, input, 1: asynchronous active-low reset.
REQ-006 Port ioctl_download, input, 1: download window active, from hps_io.
REQ-007 Port ioctl_wr, input, 1: byte-valid strobe; may be high on consecutive cycles.
REQ-008 Port ioctl_addr, input, 25: byte address of ioctl_dout.
REQ-009 Port ioctl_dout, input, 8: download byte.
REQ-010 Port dn_addr, output, 16: registered ROM write address to the core.
REQ-011 Port dn_data, output, 8: registered ROM write data to the core.
REQ-012 Port dn_wr, output, 1: one-cycle ROM write strobe to the core.
REQ-013 Port core_reset, output, 1: active-high reset request for the core.
REQ-014 Port rom_ok, output, 1: a valid image is loaded.
REQ-015 Port dl_err, output, 1: the last download was short, overflowed or failed the checksum.
REQ-016 Port byte_cnt, output, 17: bytes accepted during the current or last download; saturates at 17'h1FFFF.

Function
REQ-017 States are IDLE, LOAD, HOLD, DONE and ERR.
REQ-018 IDLE -> LOAD on ioctl_download=1; on entry, byte_cnt, overflow and checksum clear and rom_ok, dl_err go 0.
REQ-019 In LOAD, each cycle with ioctl_wr=1 and ioctl_addr<65536 produces dn_wr=1 exactly one cycle later, with dn_addr=ioctl_addr[15:0] and dn_data=ioctl_dout from that cycle.
REQ-020 Back-to-back ioctl_wr cycles produce back-to-back dn_wr pulses with no drop; throughput is 1 byte/cycle.
REQ-021 A write with ioctl_addr>=65536 does not assert dn_wr, sets the overflow flag and is not counted.
REQ-022 ioctl_wr outside LOAD is ignored (no dn_wr, no count).
REQ-023 LOAD -> HOLD on ioctl_download falling; a write in that same cycle is still accepted.
REQ-024 HOLD counts HOLD_CYC cycles, then goes to DONE if byte_cnt==EXP_BYTES and there is no overflow (and the checksum passes when enabled); otherwise it goes to ERR.
REQ-025 DONE sets rom_ok=1; ERR sets dl_err=1; both return to LOAD on a new ioctl_download rise.
REQ-026 core_reset = 1 in IDLE, LOAD, HOLD and ERR; core_reset = 0 only in DONE.
REQ-027 ioctl_download re-asserting during HOLD returns to LOAD and reinitialises per REQ-018.

Reset
REQ-028 reset_n=0 forces IDLE, dn_wr=0, dn_addr=0, dn_data=0, byte_cnt=0, rom_ok=0, dl_err=0 and core_reset=1, immediately and asynchronously.
REQ-029 Reset mid-LOAD discards progress; after release, a new ioctl_download rise is required to reach LOAD.

Configuration
REQ-030 With DL_CHECKSUM_EN defined, the router accumulates an 8-bit modulo-256 sum of accepted bytes, and DONE additionally requires sum==CHK_EXP.
REQ-031 Without DL_CHECKSUM_EN, no sum logic exists and CHK_EXP is unused.

Verification
REQ-032 Full image: download 40960 bytes at addr 0..40959, one every cycle -> 40960 dn_wr pulses, each 1 cycle after its ioctl_wr with matching addr/data; HOLD_CYC=16 cycles after ioctl_download falls, rom_ok=1 and core_reset=0.
REQ-033 Short image: 40959 bytes -> byte_cnt=40959, dl_err=1, rom_ok=0, core_reset stays 1.
REQ-034 Overflow: 40960 bytes plus one write at addr 0x10000 -> no dn_wr for that write, byte_cnt=40960, dl_err=1.
REQ-035 Reset mid-load: reset_n pulsed low after byte 100 -> dn_wr=0 and core_reset=1 immediately; with ioctl_download still high after release, the block stays in IDLE until ioctl_download falls and rises again.
REQ-036 Reload: after DONE, assert ioctl_download -> rom_ok=0, core_reset=1 and byte_cnt=0 on the next cycle.
REQ-037 Checksum (DL_CHECKSUM_EN, CHK_EXP=8'h00): image whose bytes sum to 8'h01 -> dl_err=1; a corrected image -> rom_ok=1.

Source files
------------

// File: rtl/dl_rom_router.sv
// dl_rom_router: turns the hps_io ioctl download stream into registered ROM
// write strobes for the core, counts accepted bytes, holds the core in reset
// while an image is arriving and reports whether the loaded image is valid.
// Optional feature macro: DL_CHECKSUM_EN adds an 8-bit additive checksum that
// must equal CHK_EXP before the image is accepted.
// HOLD_CYC must be at least 1.
module dl_rom_router #(
  parameter int          EXP_BYTES = 40960,
  parameter int          HOLD_CYC  = 16,
  parameter logic [7:0]  CHK_EXP   = 8'h00
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [15:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  output logic        core_reset,
  output logic        rom_ok,
  output logic        dl_err,
  output logic [16:0] byte_cnt
);

  typedef enum logic [2:0] {IDLE, LOAD, HOLD, DONE, ERR} state_t;

  localparam int          HW        = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
  localparam logic [16:0] EXP_CNT   = 17'(EXP_BYTES);
  localparam logic [16:0] CNT_MAX   = 17'h1FFFF;

  state_t        state;
  state_t        state_nxt;
  logic          dl_prev;
  logic          dl_rise;
  logic          load_start;
  logic          accept;
  logic          ovf_hit;
  logic          overflow;
  logic [HW-1:0] hold_cnt;
  logic          chk_ok;
  logic          image_good;

  assign dl_rise    = ioctl_download & ~dl_prev;
  assign accept     = (state == LOAD) & ioctl_wr & (ioctl_addr[24:16] == 9'd0);
  assign ovf_hit    = (state == LOAD) & ioctl_wr & (|ioctl_addr[24:16]);
  assign image_good = (byte_cnt == EXP_CNT) & ~overflow & chk_ok;

  assign core_reset = (state != DONE);
  assign rom_ok     = (state == DONE);
  assign dl_err     = (state == ERR);

`ifdef DL_CHECKSUM_EN
  logic [7:0] chk_sum;

  // Running modulo-256 sum of every byte forwarded to the core
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      chk_sum <= 8'h00;
    end else if (load_start) begin
      chk_sum <= 8'h00;
    end else if (accept) begin
      chk_sum <= chk_sum + ioctl_dout;
    end
  end

  assign chk_ok = (chk_sum == CHK_EXP);
`else
  logic unused_chk;
  assign unused_chk = ^CHK_EXP;
  assign chk_ok     = 1'b1;
`endif

  // State register plus download edge history; history resets high so a
  // download left asserted across reset must drop and rise again to restart
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      dl_prev <= 1'b1;
    end else begin
      state   <= state_nxt;
      dl_prev <= ioctl_download;
    end
  end

  // Next-state logic; load_start marks every entry into LOAD
  always_comb begin
    state_nxt  = state;
    load_start = 1'b0;
    case (state)
      IDLE: begin
        if (dl_rise) begin
          state_nxt  = LOAD;
          load_start = 1'b1;
        end
      end
      LOAD: begin
        if (!ioctl_download) state_nxt = HOLD;
      end
      HOLD: begin
        if (dl_rise) begin
          state_nxt  = LOAD;
          load_start = 1'b1;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nxt = image_good ? DONE : ERR;
        end
      end
      DONE, ERR: begin
        if (dl_rise) begin
          state_nxt  = LOAD;
          load_start = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One-cycle-delayed ROM write port toward the core
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dn_wr   <= 1'b0;
      dn_addr <= 16'h0000;
      dn_data <= 8'h00;
    end else begin
      dn_wr <= accept;
      if (accept) begin
        dn_addr <= ioctl_addr[15:0];
        dn_data <= ioctl_dout;
      end
    end
  end

  // Saturating accepted-byte counter and sticky overflow flag for this download
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      byte_cnt <= 17'd0;
      overflow <= 1'b0;
    end else if (load_start) begin
      byte_cnt <= 17'd0;
      overflow <= 1'b0;
    end else begin
      if (accept && (byte_cnt != CNT_MAX)) byte_cnt <= byte_cnt + 17'd1;
      if (ovf_hit) overflow <= 1'b1;
    end
  end

  // Cycles spent in HOLD; restarts from zero each time HOLD is entered
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt <= '0;
    end else if (state == HOLD) begin
      hold_cnt <= hold_cnt + 1'b1;
    end else begin
      hold_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_dl_rom_router.sv
// tb_dl_rom_router: self-checking bench for dl_rom_router, using a reduced
// EXP_BYTES so complete images stay short. Define DL_CHECKSUM_EN to also
// exercise the checksum path.
module tb_dl_rom_router;

  localparam int         EXP  = 1024;
  localparam int         HOLD = 16;
  localparam logic [7:0] CHK  = 8'h00;

  logic        clk_sys;
  logic        reset_n;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic        core_reset;
  logic        rom_ok;
  logic        dl_err;
  logic [16:0] byte_cnt;

  int compared;
  int mismatched;

  typedef struct {
    logic        wr;
    logic [24:0] addr;
    logic [7:0]  dout;
    logic        exp_wr;
    logic [15:0] exp_addr;
    logic [7:0]  exp_data;
    logic [16:0] exp_cnt;
  } vec_t;

  vec_t vecs[7];

  dl_rom_router #(.EXP_BYTES(EXP), .HOLD_CYC(HOLD), .CHK_EXP(CHK)) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .dn_addr        (dn_addr),
    .dn_data        (dn_data),
    .dn_wr          (dn_wr),
    .core_reset     (core_reset),
    .rom_ok         (rom_ok),
    .dl_err         (dl_err),
    .byte_cnt       (byte_cnt)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(negedge clk_sys);
  endtask

  task automatic applyStimulus(input logic dl, input logic wr,
                               input logic [24:0] addr, input logic [7:0] dout);
    ioctl_download = dl;
    ioctl_wr       = wr;
    ioctl_addr     = addr;
    ioctl_dout     = dout;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one complete download, last byte coinciding with the download
  // falling; leaves the bench at the negedge right after the final result edge
  task automatic runDownload(input string tag, input int nbytes,
                             input bit addOvf, input logic [7:0] sumTarget);
    logic [7:0] sum;
    logic [7:0] d;
    bit         last;
    applyStimulus(1'b1, 1'b0, 25'd0, 8'h00);
    tick();
    checkOutput({tag, "_start_cnt"},   32'(byte_cnt),   32'd0);
    checkOutput({tag, "_start_romok"}, 32'(rom_ok),     32'd0);
    checkOutput({tag, "_start_err"},   32'(dl_err),     32'd0);
    checkOutput({tag, "_start_crst"},  32'(core_reset), 32'd1);
    sum = 8'h00;
    for (int i = 0; i < nbytes; i++) begin
      last = (i == nbytes - 1);
      if (last && addOvf) begin
        applyStimulus(1'b1, 1'b1, 25'h10000, 8'hEE);
        tick();
        checkOutput({tag, "_ovf_dnwr"}, 32'(dn_wr), 32'd0);
      end
      d = last ? 8'(sumTarget - sum) : 8'(i * 13 + 7);
      sum = sum + d;
      applyStimulus(!last, 1'b1, 25'(i), d);
      tick();
      checkOutput($sformatf("%s_byte%0d", tag, i),
                  {7'd0, dn_wr, dn_addr, dn_data}, {7'd0, 1'b1, 16'(i), d});
    end
    applyStimulus(1'b0, 1'b0, 25'd0, 8'h00);
    repeat (HOLD - 1) tick();
    checkOutput({tag, "_hold_romok"}, 32'(rom_ok),     32'd0);
    checkOutput({tag, "_hold_err"},   32'(dl_err),     32'd0);
    checkOutput({tag, "_hold_crst"},  32'(core_reset), 32'd1);
    tick();
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;

    vecs[0] = '{1'b1, 25'h0000000, 8'h11, 1'b1, 16'h0000, 8'h11, 17'd1};
    vecs[1] = '{1'b1, 25'h0000001, 8'h22, 1'b1, 16'h0001, 8'h22, 17'd2};
    vecs[2] = '{1'b0, 25'h0000002, 8'h33, 1'b0, 16'h0000, 8'h00, 17'd2};
    vecs[3] = '{1'b1, 25'h000FFFF, 8'h44, 1'b1, 16'hFFFF, 8'h44, 17'd3};
    vecs[4] = '{1'b1, 25'h0010000, 8'h55, 1'b0, 16'h0000, 8'h00, 17'd3};
    vecs[5] = '{1'b1, 25'h1FFFFFF, 8'h66, 1'b0, 16'h0000, 8'h00, 17'd3};
    vecs[6] = '{1'b1, 25'h0000002, 8'h77, 1'b1, 16'h0002, 8'h77, 17'd4};

    // Reset values
    reset_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 25'd0, 8'h00);
    #3;
    checkOutput("rst_dnwr",  32'(dn_wr),      32'd0);
    checkOutput("rst_addr",  32'(dn_addr),    32'd0);
    checkOutput("rst_data",  32'(dn_data),    32'd0);
    checkOutput("rst_cnt",   32'(byte_cnt),   32'd0);
    checkOutput("rst_romok", 32'(rom_ok),     32'd0);
    checkOutput("rst_err",   32'(dl_err),     32'd0);
    checkOutput("rst_crst",  32'(core_reset), 32'd1);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();

    // Writes outside LOAD are ignored
    applyStimulus(1'b0, 1'b1, 25'd5, 8'hAB);
    tick();
    checkOutput("idle_dnwr", 32'(dn_wr),    32'd0);
    checkOutput("idle_cnt",  32'(byte_cnt), 32'd0);

    // Table of single-cycle writes inside one download
    applyStimulus(1'b1, 1'b0, 25'd0, 8'h00);
    tick();
    for (int k = 0; k < 7; k++) begin
      applyStimulus(1'b1, vecs[k].wr, vecs[k].addr, vecs[k].dout);
      tick();
      checkOutput($sformatf("vec%0d_dnwr", k), 32'(dn_wr), 32'(vecs[k].exp_wr));
      if (vecs[k].exp_wr) begin
        checkOutput($sformatf("vec%0d_addr", k), 32'(dn_addr), 32'(vecs[k].exp_addr));
        checkOutput($sformatf("vec%0d_data", k), 32'(dn_data), 32'(vecs[k].exp_data));
      end
      checkOutput($sformatf("vec%0d_cnt", k), 32'(byte_cnt), 32'(vecs[k].exp_cnt));
    end
    applyStimulus(1'b0, 1'b0, 25'd0, 8'h00);
    repeat (HOLD + 1) tick();
    checkOutput("vec_end_err",   32'(dl_err),   32'd1);
    checkOutput("vec_end_romok", 32'(rom_ok),   32'd0);
    checkOutput("vec_end_cnt",   32'(byte_cnt), 32'd4);

    // Full image
    runDownload("full", EXP, 1'b0, 8'h00);
    checkOutput("full_romok", 32'(rom_ok),     32'd1);
    checkOutput("full_crst",  32'(core_reset), 32'd0);
    checkOutput("full_err",   32'(dl_err),     32'd0);
    checkOutput("full_cnt",   32'(byte_cnt),   32'(EXP));

    // Short image, started straight from DONE (reload)
    runDownload("short", EXP - 1, 1'b0, 8'h00);
    checkOutput("short_cnt",   32'(byte_cnt),   32'(EXP - 1));
    checkOutput("short_err",   32'(dl_err),     32'd1);
    checkOutput("short_romok", 32'(rom_ok),     32'd0);
    checkOutput("short_crst",  32'(core_reset), 32'd1);

    // Full image plus one out-of-range write
    runDownload("ovf", EXP, 1'b1, 8'h00);
    checkOutput("ovf_cnt",   32'(byte_cnt), 32'(EXP));
    checkOutput("ovf_err",   32'(dl_err),   32'd1);
    checkOutput("ovf_romok", 32'(rom_ok),   32'd0);

    // Download re-asserted during HOLD restarts the load
    applyStimulus(1'b1, 1'b0, 25'd0, 8'h00);
    tick();
    applyStimulus(1'b1, 1'b1, 25'd0, 8'h01);
    tick();
    applyStimulus(1'b0, 1'b1, 25'd1, 8'h02);
    tick();
    applyStimulus(1'b0, 1'b0, 25'd0, 8'h00);
    repeat (5) tick();
    checkOutput("rehold_cnt",  32'(byte_cnt), 32'd2);
    checkOutput("rehold_err",  32'(dl_err),   32'd0);
    applyStimulus(1'b1, 1'b0, 25'd0, 8'h00);
    tick();
    checkOutput("reload_cnt",  32'(byte_cnt),   32'd0);
    checkOutput("reload_crst", 32'(core_reset), 32'd1);
    applyStimulus(1'b1, 1'b1, 25'd3, 8'h99);
    tick();
    checkOutput("reload_stream", {7'd0, dn_wr, dn_addr, dn_data}, {7'd0, 1'b1, 16'd3, 8'h99});
    applyStimulus(1'b0, 1'b0, 25'd0, 8'h00);
    repeat (HOLD + 1) tick();
    checkOutput("reload_err",     32'(dl_err),   32'd1);
    checkOutput("reload_cnt_end", 32'(byte_cnt), 32'd1);

    // Reset in the middle of a load
    applyStimulus(1'b1, 1'b0, 25'd0, 8'h00);
    tick();
    for (int i = 0; i <= 100; i++) begin
      applyStimulus(1'b1, 1'b1, 25'(i), 8'(i));
      tick();
    end
    checkOutput("midrst_pre_dnwr", 32'(dn_wr), 32'd1);
    applyStimulus(1'b1, 1'b1, 25'd101, 8'h65);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midrst_dnwr", 32'(dn_wr),      32'd0);
    checkOutput("midrst_crst", 32'(core_reset), 32'd1);
    checkOutput("midrst_cnt",  32'(byte_cnt),   32'd0);
    checkOutput("midrst_addr", 32'(dn_addr),    32'd0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 25'(5 + i), 8'h3C);
      tick();
      checkOutput($sformatf("midrst_idle%0d_dnwr", i), 32'(dn_wr),    32'd0);
      checkOutput($sformatf("midrst_idle%0d_cnt", i),  32'(byte_cnt), 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 25'd0, 8'h00);
    tick();
    applyStimulus(1'b1, 1'b1, 25'd7, 8'h5A);
    tick();
    checkOutput("midrst_rise_dnwr", 32'(dn_wr), 32'd0);
    applyStimulus(1'b1, 1'b1, 25'd8, 8'h5B);
    tick();
    checkOutput("midrst_load_stream", {7'd0, dn_wr, dn_addr, dn_data}, {7'd0, 1'b1, 16'd8, 8'h5B});
    checkOutput("midrst_load_cnt", 32'(byte_cnt), 32'd1);
    applyStimulus(1'b0, 1'b0, 25'd0, 8'h00);
    repeat (HOLD + 1) tick();
    checkOutput("midrst_end_err", 32'(dl_err), 32'd1);

`ifdef DL_CHECKSUM_EN
    // Checksum: a bad sum is rejected, a corrected image is accepted
    runDownload("chkbad", EXP, 1'b0, 8'h01);
    checkOutput("chkbad_err",   32'(dl_err), 32'd1);
    checkOutput("chkbad_romok", 32'(rom_ok), 32'd0);
    runDownload("chkgood", EXP, 1'b0, 8'h00);
    checkOutput("chkgood_romok", 32'(rom_ok), 32'd1);
    checkOutput("chkgood_err",   32'(dl_err), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
